if_id_queue: RTL and testbench

- Parametrised successor of the IF→ID pipeline buffer.
- Replaces the single fixed register stage with a DEPTH-entry FIFO of {inst_addr, inst} pairs, using valid/ready handshakes on both sides.
- Lets IF keep fetching while ID stalls, supports pipeline flush, and presents NOP_INST to ID whenever no valid instruction is available.
- Sits between the fetch unit (ROM/PC) and the decoder.

---
 rtl/if_id_queue_if.sv | 28 ++
 rtl/if_id_queue.sv | 91 +++++++++
 tb/tb_if_id_queue.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// IF->ID queue handshake bundle: fetch-side push, decode-side pop, occupancy.
// Ports: master drives fetch/decode controls, slave (the queue) drives head/ready/count.
interface if_id_queue_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INST_WIDTH  = 32,
    parameter int COUNT_WIDTH = 2
);
    logic                   pipeline_flush_i;
    logic                   inst_valid_i;
    logic [ADDR_WIDTH-1:0]  inst_addr_i;
    logic [INST_WIDTH-1:0]  inst_i;
    logic                   inst_ready_o;
    logic                   inst_valid_o;
    logic [ADDR_WIDTH-1:0]  inst_addr_o;
    logic [INST_WIDTH-1:0]  inst_o;
    logic                   id_ready_i;
    logic [COUNT_WIDTH-1:0] count_o;

    modport master (
        output pipeline_flush_i, inst_valid_i, inst_addr_i, inst_i, id_ready_i,
        input  inst_ready_o, inst_valid_o, inst_addr_o, inst_o, count_o
    );

    modport slave (
        input  pipeline_flush_i, inst_valid_i, inst_addr_i, inst_i, id_ready_i,
        output inst_ready_o, inst_valid_o, inst_addr_o, inst_o, count_o
    );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry IF->ID FIFO of {addr, inst}; NOP/RST_ADDR shown when empty.
// Ports: clk, rst_n (sync, active-low), bus (slave). IF_ID_QUEUE_BYPASS_EN adds empty-queue forwarding.
module if_id_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter int                    DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] RST_ADDR   = '0,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'h0000_0013)
) (
    input logic          clk,
    input logic          rst_n,
    if_id_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          ready;
    logic          byp;
    logic          push;
    logic          pop;

    assign empty = (count == '0);
    assign ready = (count != FULL);

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign byp = empty & bus.inst_valid_i & bus.id_ready_i
               & ~bus.pipeline_flush_i;
`else
    assign byp = 1'b0;
`endif

    // A bypassed pair is consumed on the spot, so it is never written.
    assign push = bus.inst_valid_i & ready & ~bus.pipeline_flush_i & ~byp;
    assign pop  = ~empty & bus.id_ready_i & ~bus.pipeline_flush_i;

    always_comb begin
        head = '{addr: RST_ADDR, inst: NOP_INST};
        unique case (1'b1)
            ~empty:  head = mem[rd_ptr];
            byp:     head = '{addr: bus.inst_addr_i, inst: bus.inst_i};
            default: head = '{addr: RST_ADDR, inst: NOP_INST};
        endcase
    end

    assign bus.inst_ready_o = ready;
    assign bus.inst_valid_o = ~empty | byp;
    assign bus.inst_addr_o  = head.addr;
    assign bus.inst_o       = head.inst;
    assign bus.count_o      = count;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.pipeline_flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= '{addr: bus.inst_addr_i, inst: bus.inst_i};
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n)
            assert (count <= FULL)
            else $error("if_id_queue occupancy above DEPTH: %0d", count);
    end
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=2).
// Ports: none; drives the queue through an if_id_queue_if instance.
module tb_if_id_queue;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    if_id_queue_if #(.ADDR_WIDTH(32), .INST_WIDTH(32), .COUNT_WIDTH(CW)) bus ();

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] a,
                         input logic [31:0] i);
        bus.inst_valid_i = v;
        bus.inst_addr_i  = a;
        bus.inst_i       = i;
    endtask

    initial begin
        rst_n                = 1'b0;
        bus.pipeline_flush_i = 1'b0;
        bus.id_ready_i       = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        check("rst_valid", 64'(bus.inst_valid_o), 64'd0);
        check("rst_inst",  64'(bus.inst_o), 64'h13);
        check("rst_addr",  64'(bus.inst_addr_o), 64'h0);
        check("rst_count", 64'(bus.count_o), 64'd0);
        check("rst_ready", 64'(bus.inst_ready_o), 64'd1);

        offer(1'b1, 32'h100, 32'hAAAA_0001);
        step();
        check("fill1_count", 64'(bus.count_o), 64'd1);
        check("fill1_addr",  64'(bus.inst_addr_o), 64'h100);
        offer(1'b1, 32'h104, 32'hAAAA_0002);
        step();
        check("full_count", 64'(bus.count_o), 64'd2);
        check("full_ready", 64'(bus.inst_ready_o), 64'd0);
        offer(1'b1, 32'h108, 32'hAAAA_0003);
        step();
        check("rej_count", 64'(bus.count_o), 64'd2);
        check("rej_addr",  64'(bus.inst_addr_o), 64'h100);
        check("rej_inst",  64'(bus.inst_o), 64'hAAAA_0001);

        offer(1'b0, 32'h0, 32'h0);
        bus.id_ready_i = 1'b1;
        check("drain0_valid", 64'(bus.inst_valid_o), 64'd1);
        step();
        check("drain1_addr",  64'(bus.inst_addr_o), 64'h104);
        check("drain1_inst",  64'(bus.inst_o), 64'hAAAA_0002);
        check("drain1_count", 64'(bus.count_o), 64'd1);
        step();
        check("drain2_valid", 64'(bus.inst_valid_o), 64'd0);
        check("drain2_inst",  64'(bus.inst_o), 64'h13);
        check("drain2_count", 64'(bus.count_o), 64'd0);
        bus.id_ready_i = 1'b0;

        offer(1'b1, 32'h200, 32'hBBBB_0000);
        step();
        check("stream_pre", 64'(bus.count_o), 64'd1);
        bus.id_ready_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            offer(1'b1, 32'h200 + 32'(4 * i), 32'hBBBB_0000 + 32'(i));
            step();
            check($sformatf("stream%0d_addr", i), 64'(bus.inst_addr_o),
                  64'(32'h200 + 32'(4 * i)));
            check($sformatf("stream%0d_inst", i), 64'(bus.inst_o),
                  64'(32'hBBBB_0000 + 32'(i)));
            check($sformatf("stream%0d_count", i), 64'(bus.count_o), 64'd1);
        end
        offer(1'b0, 32'h0, 32'h0);
        step();
        check("stream_end_valid", 64'(bus.inst_valid_o), 64'd0);
        bus.id_ready_i = 1'b0;

        offer(1'b1, 32'h280, 32'hCCCC_0000);
        step();
        offer(1'b1, 32'h284, 32'hCCCC_0001);
        step();
        check("pfl_count", 64'(bus.count_o), 64'd2);
        bus.pipeline_flush_i = 1'b1;
        offer(1'b1, 32'h300, 32'hDDDD_0000);
        #1;
        check("fl_cycle_valid", 64'(bus.inst_valid_o), 64'd1);
        check("fl_cycle_addr",  64'(bus.inst_addr_o), 64'h280);
        step();
        check("fl_count", 64'(bus.count_o), 64'd0);
        check("fl_valid", 64'(bus.inst_valid_o), 64'd0);
        check("fl_inst",  64'(bus.inst_o), 64'h13);
        check("fl_addr",  64'(bus.inst_addr_o), 64'h0);
        bus.pipeline_flush_i = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        step();
        check("fl_after_count", 64'(bus.count_o), 64'd0);
        check("fl_after_addr",  64'(bus.inst_addr_o), 64'h0);

        bus.pipeline_flush_i = 1'b1;
        bus.id_ready_i       = 1'b1;
        offer(1'b1, 32'h400, 32'h1234_5678);
        #1;
        check("flbyp_valid", 64'(bus.inst_valid_o), 64'd0);
        check("flbyp_inst",  64'(bus.inst_o), 64'h13);
        step();
        bus.pipeline_flush_i = 1'b0;
        #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
        check("byp_addr",  64'(bus.inst_addr_o), 64'h400);
        check("byp_inst",  64'(bus.inst_o), 64'h1234_5678);
        check("byp_valid", 64'(bus.inst_valid_o), 64'd1);
        check("byp_count", 64'(bus.count_o), 64'd0);
        step();
        offer(1'b0, 32'h0, 32'h0);
        #1;
        check("byp_after_count", 64'(bus.count_o), 64'd0);
        check("byp_after_valid", 64'(bus.inst_valid_o), 64'd0);
`else
        check("nobyp_valid0", 64'(bus.inst_valid_o), 64'd0);
        check("nobyp_addr0",  64'(bus.inst_addr_o), 64'h0);
        step();
        check("nobyp_valid1", 64'(bus.inst_valid_o), 64'd1);
        check("nobyp_addr1",  64'(bus.inst_addr_o), 64'h400);
        check("nobyp_count1", 64'(bus.count_o), 64'd1);
        offer(1'b0, 32'h0, 32'h0);
        step();
        check("nobyp_drain", 64'(bus.count_o), 64'd0);
`endif

        bus.id_ready_i = 1'b0;
        offer(1'b1, 32'h500, 32'hEEEE_0000);
        step();
        check("mid_pre", 64'(bus.count_o), 64'd1);
        rst_n                = 1'b0;
        bus.pipeline_flush_i = 1'b0;
        step();
        check("mid_rst_count", 64'(bus.count_o), 64'd0);
        check("mid_rst_valid", 64'(bus.inst_valid_o), 64'd0);
        check("mid_rst_addr",  64'(bus.inst_addr_o), 64'h0);
        rst_n = 1'b1;
        offer(1'b0, 32'h0, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
